// File: rtl/pipe_float32_to_fixed_point_pkg.sv
// Shared float32 field layout, class encoding and the sideband that rides
// alongside the magnitude through the float-to-fixed pipeline.
package float_fixed_pkg;

    localparam int          F32_BIAS        = 127;
    localparam logic [7:0]  F32_EXP_SPECIAL = 8'hFF;
    localparam int          F32_MANT_W      = 24;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } float32_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } cls_t;

    // big: value is at least 2^WOI, so no shift can bring it into range
    typedef struct packed {
        logic valid;
        logic sign;
        cls_t cls;
        logic big;
    } side_t;

endpackage

// File: rtl/pipe_float32_to_fixed_point_if.sv
// Streaming bus of the float32 to fixed-point converter: float in, fixed out.
interface pipe_float32_to_fixed_point_if #(
    parameter int WOI = 8,
    parameter int WOF = 8
);
    localparam int W = WOI + WOF;

    logic         in_valid;
    logic [31:0]  in;
    logic         out_valid;
    logic [W-1:0] out;
    logic         ovf;

    modport master (output in_valid, in, input out_valid, out, ovf);
    modport slave  (input in_valid, in, output out_valid, out, ovf);
endinterface

// File: rtl/pipe_float32_to_fixed_point_rshift_stage.sv
// One barrel-shifter stage: conditionally right-shifts the magnitude by
// 2^SHIFT_BIT and registers data, shift amount and sideband together.
module pipe_rshift_stage #(
    parameter int DW        = 16,
    parameter int AW        = 5,
    parameter int SW        = 5,
    parameter int SHIFT_BIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    input  logic [AW-1:0] amt_in,
    input  logic [SW-1:0] side_in,
    output logic [DW-1:0] data_out,
    output logic [AW-1:0] amt_out,
    output logic [SW-1:0] side_out
);
    localparam int DIST = 1 << SHIFT_BIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            amt_out  <= '0;
            side_out <= '0;
        end else begin
            data_out <= amt_in[SHIFT_BIT] ? (data_in >> DIST) : data_in;
            amt_out  <= amt_in;
            side_out <= side_in;
        end
    end
endmodule

// File: rtl/pipe_float32_to_fixed_point.sv
// Pipelined float32 -> signed fixed-point (WOI.WOF) converter, latency SB+2.
// Define FLOAT2FIX_ROUND_EN for round-half-away-from-zero instead of truncation.
module pipe_float32_to_fixed_point #(
    parameter int WOI = 8,
    parameter int WOF = 8
) (
    input  logic clk,
    input  logic rst,
    pipe_float32_to_fixed_point_if.slave bus
);
    import float_fixed_pkg::*;

    localparam int W  = WOI + WOF;
    localparam int SB = $clog2(W + 1);
`ifdef FLOAT2FIX_ROUND_EN
    localparam int GB = 1;
`else
    localparam int GB = 0;
`endif
    localparam int MW = W + GB;
    localparam int SW = $bits(side_t);
    localparam logic signed [9:0] D_BASE = 10'(WOI - 1 + F32_BIAS);
    localparam logic signed [9:0] MW_S   = 10'(MW);
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    // ---------------- stage 0: unpack / classify ----------------
    float32_t              f;
    logic [F32_MANT_W-1:0] mant;
    logic [MW-1:0]         mag_aligned;
    logic signed [9:0]     d;
    side_t                 side_next;
    logic [MW-1:0]         mag_next;
    logic [SB-1:0]         amt_next;

    assign f    = bus.in;
    assign mant = {1'b1, f.frac};
    // top MW bits of the mantissa, MSB at weight 2^(WOI-1)
    assign mag_aligned = MW'({mant, {MW{1'b0}}} >> F32_MANT_W);
    assign d = D_BASE - $signed({2'b00, f.exp});

    always_comb begin
        side_next       = '0;
        side_next.valid = bus.in_valid;
        side_next.sign  = f.sign;
        mag_next        = '0;
        amt_next        = '0;
        if (f.exp == 8'h00) begin
            side_next.cls = CLS_ZERO;
        end else if (f.exp == F32_EXP_SPECIAL) begin
            side_next.cls = (f.frac == '0) ? CLS_INF : CLS_NAN;
        end else begin
            side_next.cls = CLS_NORM;
            side_next.big = (d < 0);
            // shifts of MW or more leave nothing, so zero the magnitude outright
            if (d < MW_S)
                mag_next = mag_aligned;
            if (d > 0 && d < MW_S)
                amt_next = d[SB-1:0];
        end
    end

    side_t         side0_reg;
    logic [MW-1:0] mag0_reg;
    logic [SB-1:0] amt0_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            side0_reg <= '0;
            mag0_reg  <= '0;
            amt0_reg  <= '0;
        end else begin
            side0_reg <= side_next;
            mag0_reg  <= mag_next;
            amt0_reg  <= amt_next;
        end
    end

    // ---------------- stages 1..SB: log shifter ----------------
    side_t         side_pipe [0:SB];
    logic [MW-1:0] mag_pipe  [0:SB];
    logic [SB-1:0] amt_pipe  [0:SB];

    assign side_pipe[0] = side0_reg;
    assign mag_pipe[0]  = mag0_reg;
    assign amt_pipe[0]  = amt0_reg;

    for (genvar gi = 0; gi < SB; gi++) begin : g_shift
        pipe_rshift_stage #(
            .DW        (MW),
            .AW        (SB),
            .SW        (SW),
            .SHIFT_BIT (gi)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .data_in  (mag_pipe[gi]),
            .amt_in   (amt_pipe[gi]),
            .side_in  (side_pipe[gi]),
            .data_out (mag_pipe[gi+1]),
            .amt_out  (amt_pipe[gi+1]),
            .side_out (side_pipe[gi+1])
        );
    end

    // ---------------- final stage: round / sign / saturate ----------------
    side_t         side_f;
    logic [MW-1:0] mag_f;
    logic [SB-1:0] amt_unused;
    logic          guard;
    logic [W:0]    sum;
    logic          is_min;
    logic          sat;
    logic [W-1:0]  out_next;
    logic          ovf_next;

    assign side_f     = side_pipe[SB];
    assign mag_f      = mag_pipe[SB];
    assign amt_unused = amt_pipe[SB];
`ifdef FLOAT2FIX_ROUND_EN
    assign guard = mag_f[0];
`else
    assign guard = 1'b0;
`endif
    assign sum = {1'b0, mag_f[MW-1 -: W]} + (W+1)'(guard);
    // -2^(WOI-1) is the one magnitude with bit W-1 set that still fits
    assign is_min = side_f.sign && (sum == {1'b0, MIN_NEG});
    assign sat    = side_f.big || ((sum[W] || sum[W-1]) && !is_min);

    always_comb begin
        out_next = '0;
        ovf_next = 1'b0;
        case (side_f.cls)
            CLS_NAN: begin
                ovf_next = 1'b1;
            end
            CLS_INF: begin
                out_next = side_f.sign ? MIN_NEG : MAX_POS;
                ovf_next = 1'b1;
            end
            CLS_NORM: begin
                if (sat) begin
                    out_next = side_f.sign ? MIN_NEG : MAX_POS;
                    ovf_next = 1'b1;
                end else begin
                    out_next = side_f.sign ? (-sum[W-1:0]) : sum[W-1:0];
                end
            end
            default: begin
                out_next = '0;
            end
        endcase
    end

    logic [W-1:0] out_reg;
    logic         ovf_reg;
    logic         out_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg       <= '0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_reg       <= out_next;
            ovf_reg       <= ovf_next;
            out_valid_reg <= side_f.valid;
        end
    end

    assign bus.out       = out_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_pipe_float32_to_fixed_point.sv
// Directed and random checks of the float32 -> Q8.8 converter, including
// specials, saturation edges, optional rounding and a mid-stream reset.
module tb_pipe_float32_to_fixed_point;
    localparam int WOI = 8;
    localparam int WOF = 8;
    localparam int W   = WOI + WOF;
    localparam int LAT = 7;
    localparam int NDIR = 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_float32_to_fixed_point_if #(.WOI(WOI), .WOF(WOF)) bus ();

    pipe_float32_to_fixed_point #(.WOI(WOI), .WOF(WOF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] din;
        logic [W:0]  want;
    } item_t;

    item_t          q[$];
    item_t          mon_it;
    logic [LAT-1:0] hist;
    int             total = 0;
    int             bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // independent reference: exact real arithmetic on the float fields
    function automatic logic [W:0] ref_conv(input logic [31:0] fv);
        int    e;
        real   v;
        longint t;
        logic  s;
        s = fv[31];
        e = int'(fv[30:23]);
        if (e == 255)
            return (fv[22:0] != 0) ? {1'b1, 16'h0000} : (s ? {1'b1, 16'h8000} : {1'b1, 16'h7FFF});
        if (e == 0)
            return '0;
        v = real'({1'b1, fv[22:0]});
        for (int k = 0; k < e - 150 + WOF; k++) v = v * 2.0;
        for (int k = 0; k < 150 - WOF - e; k++) v = v / 2.0;
        if (v >= 1.0e6)
            return s ? {1'b1, 16'h8000} : {1'b1, 16'h7FFF};
`ifdef FLOAT2FIX_ROUND_EN
        t = longint'($rtoi(v + 0.5));
`else
        t = longint'($rtoi(v));
`endif
        if (s) begin
            if (t > 32768) return {1'b1, 16'h8000};
            return {1'b0, 16'(-t)};
        end
        if (t > 32767) return {1'b1, 16'h7FFF};
        return {1'b0, 16'(t)};
    endfunction

    task automatic send(input logic v, input logic [31:0] d, input logic [W:0] want);
        item_t it;
        @(posedge clk);
        #2;
        bus.in_valid = v;
        bus.in       = d;
        if (v) begin
            it.din  = d;
            it.want = want;
            q.push_back(it);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, $urandom, '0);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) hist <= '0;
        else     hist <= {hist[LAT-2:0], bus.in_valid};
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", {31'b0, bus.out_valid}, {31'b0, hist[LAT-1]});
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("spurious", 32'(q.size()), 32'd1);
                end else begin
                    mon_it = q.pop_front();
                    $display("txn in=%h out=%h ovf=%b want=%h", mon_it.din, bus.out, bus.ovf, mon_it.want);
                    check("result", {15'b0, bus.ovf, bus.out}, {15'b0, mon_it.want});
                end
            end
        end
    end

    logic [31:0] dv [NDIR];
    logic [W:0]  de [NDIR];

    initial begin
        int          n;
        logic [31:0] fr;

        dv[0]  = 32'h3FC00000; de[0]  = 17'h00180;
        dv[1]  = 32'hC0100000; de[1]  = 17'h0FDC0;
        dv[2]  = 32'h43480000; de[2]  = 17'h17FFF;
        dv[3]  = 32'hC3000000; de[3]  = 17'h08000;
        dv[4]  = 32'hC3010000; de[4]  = 17'h18000;
        dv[5]  = 32'h7F800000; de[5]  = 17'h17FFF;
        dv[6]  = 32'hFF800000; de[6]  = 17'h18000;
        dv[7]  = 32'h7FC00000; de[7]  = 17'h10000;
        dv[8]  = 32'h80000000; de[8]  = 17'h00000;
        dv[9]  = 32'h00000001; de[9]  = 17'h00000;
        dv[10] = 32'h3B000000;
        dv[11] = 32'h42FFFF00;
`ifdef FLOAT2FIX_ROUND_EN
        de[10] = 17'h00001;
        de[11] = 17'h17FFF;
`else
        de[10] = 17'h00000;
        de[11] = 17'h07FFF;
`endif
        dv[12] = 32'h3F800000; de[12] = 17'h00100;
        dv[13] = 32'h42FE0000; de[13] = 17'h07F00;

        bus.in_valid = 1'b0;
        bus.in       = '0;
        #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out",   {16'b0, bus.out},       32'd0);
        check("rst_ovf",   {31'b0, bus.ovf},       32'd0);
        check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < NDIR; i++) send(1'b1, dv[i], de[i]);
        idle(10);

        n = 0;
        while (n < 20) begin
            if ($urandom_range(0, 2) != 0) begin
                fr = {1'($urandom), 8'($urandom_range(112, 136)), 23'($urandom)};
                send(1'b1, fr, ref_conv(fr));
                n++;
            end else begin
                send(1'b0, $urandom, '0);
            end
        end
        idle(10);

        // reset with four samples still in the pipe
        for (int i = 0; i < 4; i++) send(1'b1, 32'h3FC00000, 17'h00180);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        #1;
        check("flush_out",   {16'b0, bus.out},       32'd0);
        check("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        idle(12);

        send(1'b1, 32'h3F800000, 17'h00100);
        idle(10);

        check("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
